// File: rtl/multicycle_pkg.sv
// Shared constants for the multi-cycle MIPS control unit:
// opcodes, ALUOp codes, FSM state encodings and datapath mux selects.
package multicycle_pkg;

   // Opcodes (IR[31:26]) and the JR function code (IR[5:0])
   localparam logic [5:0] OP_R     = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] FUNCT_JR = 6'h08;

   // ALUOp codes; ADD shares the ADDI encoding
   localparam logic [3:0] ALU_R    = 4'd0;
   localparam logic [3:0] ALU_ADDI = 4'd1;
   localparam logic [3:0] ALU_ORI  = 4'd2;
   localparam logic [3:0] ALU_LUI  = 4'd3;
   localparam logic [3:0] ALU_ANDI = 4'd4;
   localparam logic [3:0] ALU_BEQ  = 4'd5;
   localparam logic [3:0] ALU_BNE  = 4'd6;
   localparam logic [3:0] ALU_LW   = 4'd7;
   localparam logic [3:0] ALU_SW   = 4'd8;
   localparam logic [3:0] ALU_ADD  = 4'd1;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC_R  = 4'd6,
      S_ALUWB_R = 4'd7,
      S_EXEC_I  = 4'd8,
      S_ALUWB_I = 4'd9,
      S_BRANCH  = 4'd10,
      S_JUMP    = 4'd11,
      S_JAL     = 4'd12,
      S_JR      = 4'd13
   } state_t;

   localparam logic [1:0] MTR_ALUOUT = 2'd0;
   localparam logic [1:0] MTR_MDR    = 2'd1;
   localparam logic [1:0] MTR_PC     = 2'd2;

   localparam logic [1:0] RD_RT = 2'd0;
   localparam logic [1:0] RD_RD = 2'd1;
   localparam logic [1:0] RD_RA = 2'd2;

   localparam logic [1:0] SRCB_B     = 2'd0;
   localparam logic [1:0] SRCB_4     = 2'd1;
   localparam logic [1:0] SRCB_IMM   = 2'd2;
   localparam logic [1:0] SRCB_IMMSH = 2'd3;

   localparam logic [1:0] PCS_ALU    = 2'd0;
   localparam logic [1:0] PCS_ALUOUT = 2'd1;
   localparam logic [1:0] PCS_JUMP   = 2'd2;
   localparam logic [1:0] PCS_A      = 2'd3;

   // ALU operation for the immediate-ALU execute state
   function automatic logic [3:0] alu_code_i(input logic [5:0] op);
      case (op)
         OP_ADDI: return ALU_ADDI;
         OP_ORI:  return ALU_ORI;
         OP_LUI:  return ALU_LUI;
         OP_ANDI: return ALU_ANDI;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_next_state.sv
// Combinational next-state decode for the multi-cycle control FSM.
// Ports: i_state/i_op/i_funct/i_mem_ready in; o_next, o_illegal out.
module multicycle_next_state
   import multicycle_pkg::*;
#(
   parameter int MEM_HANDSHAKE = 1,
   parameter int EN_JAL_JR     = 1
) (
   input  state_t     i_state,
   input  logic [5:0] i_op,
   input  logic [5:0] i_funct,
   input  logic       i_mem_ready,
   output state_t     o_next,
   output logic       o_illegal
);

   logic w_rdy;
   logic w_jr;

   // Without the handshake every memory access completes in one cycle
   assign w_rdy = i_mem_ready || (MEM_HANDSHAKE == 0);
   assign w_jr  = (EN_JAL_JR != 0) && (i_funct == FUNCT_JR);

   always_comb begin
      o_next    = S_FETCH;
      o_illegal = 1'b0;
      case (i_state)
         S_FETCH:  o_next = w_rdy ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (i_op)
               OP_LW, OP_SW: o_next = S_MEMADR;
               OP_R:         o_next = w_jr ? S_JR : S_EXEC_R;
               OP_ADDI, OP_ORI,
               OP_LUI, OP_ANDI: o_next = S_EXEC_I;
               OP_BEQ, OP_BNE:  o_next = S_BRANCH;
               OP_J:         o_next = S_JUMP;
               OP_JAL: begin
                  if (EN_JAL_JR != 0) o_next = S_JAL;
                  else                o_illegal = 1'b1;
               end
               default:      o_illegal = 1'b1;
            endcase
         end
         S_MEMADR: o_next = (i_op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  o_next = w_rdy ? S_MEMWB : S_MEMRD;
         S_MEMWR:  o_next = w_rdy ? S_FETCH : S_MEMWR;
         S_EXEC_R: o_next = S_ALUWB_R;
         S_EXEC_I: o_next = S_ALUWB_I;
         default:  o_next = S_FETCH;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: Moore FSM over fetch/decode/execute/
// memory/writeback driving the shared-memory datapath selects/strobes.
// Ports: clk, reset (sync, active-low), OP/Funct from IR, mem_ready;
// datapath controls, ALUOp, debug state and illegal_op out.
module multicycle_control
   import multicycle_pkg::*;
#(
   parameter int ALUOP_W       = 4,
   parameter int MEM_HANDSHAKE = 1,
   parameter int EN_JAL_JR     = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         OP,
   input  logic [5:0]         Funct,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               PCWriteCondEQ,
   output logic               PCWriteCondNE,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic [1:0]         MemtoReg,
   output logic [1:0]         RegDst,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         PCSource,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic [3:0]         state,
   output logic               illegal_op
);

   state_t r_state;
   state_t w_next;
   logic   w_illegal;
   logic   w_fetch_done;

   multicycle_next_state #(
      .MEM_HANDSHAKE (MEM_HANDSHAKE),
      .EN_JAL_JR     (EN_JAL_JR)
   ) u_next (
      .i_state     (r_state),
      .i_op        (OP),
      .i_funct     (Funct),
      .i_mem_ready (mem_ready),
      .o_next      (w_next),
      .o_illegal   (w_illegal)
   );

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   // IR/PC load exactly once, in the cycle the fetch read completes
   assign w_fetch_done = mem_ready || (MEM_HANDSHAKE == 0);

   assign state      = r_state;
   assign illegal_op = w_illegal;

   always_comb begin
      PCWrite       = 1'b0;
      PCWriteCondEQ = 1'b0;
      PCWriteCondNE = 1'b0;
      IorD          = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      MemtoReg      = MTR_ALUOUT;
      RegDst        = RD_RT;
      RegWrite      = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = SRCB_B;
      PCSource      = PCS_ALU;
      ALUOp         = '0;
      case (r_state)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_4;
            ALUOp   = ALUOP_W'(ALU_ADD);
            IRWrite = w_fetch_done;
            PCWrite = w_fetch_done;
         end
         S_DECODE: begin
            ALUSrcB = SRCB_IMMSH;
            ALUOp   = ALUOP_W'(ALU_ADD);
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_W'(ALU_ADD);
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            RegDst   = RD_RT;
            MemtoReg = MTR_MDR;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         S_EXEC_R: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_B;
            ALUOp   = ALUOP_W'(ALU_R);
         end
         S_ALUWB_R: begin
            RegWrite = 1'b1;
            RegDst   = RD_RD;
         end
         S_EXEC_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_W'(alu_code_i(OP));
         end
         S_ALUWB_I: begin
            RegWrite = 1'b1;
            RegDst   = RD_RT;
         end
         S_BRANCH: begin
            ALUSrcA       = 1'b1;
            ALUSrcB       = SRCB_B;
            PCSource      = PCS_ALUOUT;
            PCWriteCondEQ = (OP == OP_BEQ);
            PCWriteCondNE = (OP == OP_BNE);
            ALUOp = (OP == OP_BNE) ? ALUOP_W'(ALU_BNE)
                                   : ALUOP_W'(ALU_BEQ);
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = PCS_JUMP;
         end
         // Link source is the PC already advanced during FETCH
         S_JAL: begin
            PCWrite  = 1'b1;
            PCSource = PCS_JUMP;
            RegWrite = 1'b1;
            RegDst   = RD_RA;
            MemtoReg = MTR_PC;
         end
         S_JR: begin
            PCWrite  = 1'b1;
            PCSource = PCS_A;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: default build (a_*) and a
// build without JAL/JR (b_*) run side by side on shared inputs.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] OP;
   logic [5:0] Funct;
   logic       mem_ready;

   logic       a_pcw, a_ceq, a_cne, a_iord, a_mrd, a_mwr, a_irw;
   logic [1:0] a_m2r, a_rdst, a_srcb, a_pcs;
   logic       a_rw, a_srca, a_ill;
   logic [3:0] a_aluop, a_state;

   logic       b_pcw, b_ceq, b_cne, b_iord, b_mrd, b_mwr, b_irw;
   logic [1:0] b_m2r, b_rdst, b_srcb, b_pcs;
   logic       b_rw, b_srca, b_ill;
   logic [3:0] b_aluop, b_state;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   multicycle_control u_a (
      .clk(clk), .reset(reset), .OP(OP), .Funct(Funct),
      .mem_ready(mem_ready),
      .PCWrite(a_pcw), .PCWriteCondEQ(a_ceq), .PCWriteCondNE(a_cne),
      .IorD(a_iord), .MemRead(a_mrd), .MemWrite(a_mwr),
      .IRWrite(a_irw), .MemtoReg(a_m2r), .RegDst(a_rdst),
      .RegWrite(a_rw), .ALUSrcA(a_srca), .ALUSrcB(a_srcb),
      .PCSource(a_pcs), .ALUOp(a_aluop), .state(a_state),
      .illegal_op(a_ill)
   );

   multicycle_control #(.EN_JAL_JR(0)) u_b (
      .clk(clk), .reset(reset), .OP(OP), .Funct(Funct),
      .mem_ready(mem_ready),
      .PCWrite(b_pcw), .PCWriteCondEQ(b_ceq), .PCWriteCondNE(b_cne),
      .IorD(b_iord), .MemRead(b_mrd), .MemWrite(b_mwr),
      .IRWrite(b_irw), .MemtoReg(b_m2r), .RegDst(b_rdst),
      .RegWrite(b_rw), .ALUSrcA(b_srca), .ALUSrcB(b_srcb),
      .PCSource(b_pcs), .ALUOp(b_aluop), .state(b_state),
      .illegal_op(b_ill)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after driving inputs
   task automatic settle();
      #1;
   endtask

   initial begin
      reset = 1'b0; mem_ready = 1'b0; OP = 6'h00; Funct = 6'h00;
      tick(); tick();
      settle();
      chk("rst_state", a_state, 0);
      chk("rst_irw", a_irw, 0);

      // ADDI with mem_ready high: 0,1,8,9,0
      reset = 1'b1; OP = 6'h08; mem_ready = 1'b1;
      settle();
      chk("addi_f_state", a_state, 0);
      chk("addi_f_irw", a_irw, 1);
      chk("addi_f_pcw", a_pcw, 1);
      chk("addi_f_mrd", a_mrd, 1);
      chk("addi_f_srcb", a_srcb, 1);
      chk("addi_f_aluop", a_aluop, 1);
      tick(); settle();
      chk("addi_d_state", a_state, 1);
      chk("addi_d_srcb", a_srcb, 3);
      chk("addi_d_irw", a_irw, 0);
      chk("addi_d_ill", a_ill, 0);
      tick(); settle();
      chk("addi_e_state", a_state, 8);
      chk("addi_e_aluop", a_aluop, 1);
      chk("addi_e_srcb", a_srcb, 2);
      chk("addi_e_rw", a_rw, 0);
      tick(); settle();
      chk("addi_w_state", a_state, 9);
      chk("addi_w_rw", a_rw, 1);
      chk("addi_w_rdst", a_rdst, 0);
      chk("addi_w_m2r", a_m2r, 0);
      tick(); settle();
      chk("addi_back", a_state, 0);

      // LW with 3 wait cycles in MEMRD: 8 cycles total
      OP = 6'h23; mem_ready = 1'b1;
      tick(); settle();
      chk("lw_d_state", a_state, 1);
      tick();
      mem_ready = 1'b0;
      settle();
      chk("lw_a_state", a_state, 2);
      chk("lw_a_srca", a_srca, 1);
      chk("lw_a_srcb", a_srcb, 2);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 3) mem_ready = 1'b1;
         settle();
         chk("lw_rd_state", a_state, 3);
         chk("lw_rd_mrd", a_mrd, 1);
         chk("lw_rd_iord", a_iord, 1);
         chk("lw_rd_rw", a_rw, 0);
      end
      tick(); settle();
      chk("lw_wb_state", a_state, 4);
      chk("lw_wb_rw", a_rw, 1);
      chk("lw_wb_m2r", a_m2r, 1);
      chk("lw_wb_rdst", a_rdst, 0);
      tick(); settle();
      chk("lw_back", a_state, 0);

      // Reset held low 2 cycles while stalled in MEMRD
      tick(); tick();
      mem_ready = 1'b0;
      tick(); settle();
      chk("rmid_memrd", a_state, 3);
      reset = 1'b0;
      tick(); settle();
      chk("rmid_state0", a_state, 0);
      chk("rmid_irw0", a_irw, 0);
      chk("rmid_rw0", a_rw, 0);
      tick(); settle();
      chk("rmid_state1", a_state, 0);
      chk("rmid_pcw1", a_pcw, 0);
      reset = 1'b1;
      tick(); settle();
      chk("rmid_hold", a_state, 0);
      chk("rmid_hold_irw", a_irw, 0);
      chk("rmid_hold_rw", a_rw, 0);
      OP = 6'h05; mem_ready = 1'b1;
      settle();
      chk("rmid_rdy_irw", a_irw, 1);
      chk("rmid_rdy_pcw", a_pcw, 1);

      // BNE: 0,1,10,0
      tick(); settle();
      chk("bne_d_state", a_state, 1);
      tick(); settle();
      chk("bne_b_state", a_state, 10);
      chk("bne_b_cne", a_cne, 1);
      chk("bne_b_ceq", a_ceq, 0);
      chk("bne_b_pcs", a_pcs, 1);
      chk("bne_b_aluop", a_aluop, 6);
      chk("bne_b_pcw", a_pcw, 0);
      tick(); settle();
      chk("bne_back", a_state, 0);

      // JAL: supported in u_a, illegal in u_b
      OP = 6'h03;
      tick(); settle();
      chk("jal_a_ill", a_ill, 0);
      chk("jal_b_state", b_state, 1);
      chk("jal_b_ill", b_ill, 1);
      tick();
      mem_ready = 1'b0;
      settle();
      chk("jal_a_state", a_state, 12);
      chk("jal_a_rdst", a_rdst, 2);
      chk("jal_a_m2r", a_m2r, 2);
      chk("jal_a_pcs", a_pcs, 2);
      chk("jal_a_pcw", a_pcw, 1);
      chk("jal_a_rw", a_rw, 1);
      chk("jal_b_back", b_state, 0);
      chk("jal_b_rw", b_rw, 0);
      chk("jal_b_pcw", b_pcw, 0);
      chk("jal_b_mwr", b_mwr, 0);
      chk("jal_b_ill0", b_ill, 0);
      tick(); settle();
      chk("jal_a_back", a_state, 0);

      // JR: R-type funct 0x08
      OP = 6'h00; Funct = 6'h08; mem_ready = 1'b1;
      tick(); tick(); settle();
      chk("jr_a_state", a_state, 13);
      chk("jr_a_pcs", a_pcs, 3);
      chk("jr_a_pcw", a_pcw, 1);
      chk("jr_a_rw", a_rw, 0);
      chk("jr_b_state", b_state, 6);
      chk("jr_b_aluop", b_aluop, 0);
      tick(); settle();
      chk("jr_a_back", a_state, 0);
      chk("jr_b_wb", b_state, 7);
      chk("jr_b_rdst", b_rdst, 1);

      // Unknown opcode in u_a
      OP = 6'h3f;
      tick(); settle();
      chk("ill_d_state", a_state, 1);
      chk("ill_pulse", a_ill, 1);
      tick(); settle();
      chk("ill_back", a_state, 0);
      chk("ill_clear", a_ill, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control unit for the MIPS datapath; it replaces the single-cycle opcode decoder.
- A Moore FSM sequences each instruction over 3-5 states: fetch, decode, execute, memory, writeback.
- Memory accesses stall on a ready handshake.
- Sits between the instruction register (op/funct) and the shared-memory multi-cycle datapath (PC, IR, MDR, A/B, ALUOut registers).

Parameters:
ALUOP_W, 4, width of ALUOp output; must be >= 4.
MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored, 1-cycle memory.
EN_JAL_JR, 1, 1 = JAL and JR (R-type funct 6'h08) supported; 0 = both decode as illegal / plain R-type.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
OP  in  6  IR[31:26]
Funct  in  6  IR[5:0]
mem_ready  in  1  memory completed current read/write this cycle
PCWrite  out  1  unconditional PC load
PCWriteCondEQ  out  1  PC load if ALU zero
PCWriteCondNE  out  1  PC load if ALU not zero
IorD  out  1  0 = PC addresses memory, 1 = ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  load IR
MemtoReg  out  2  0 = ALUOut, 1 = MDR, 2 = PC (link)
RegDst  out  2  0 = rt, 1 = rd, 2 = $ra (31)
RegWrite  out  1  register file write
ALUSrcA  out  1  0 = PC, 1 = A
ALUSrcB  out  2  0 = B, 1 = 4, 2 = signext imm, 3 = signext imm<<2
PCSource  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = A (JR)
ALUOp  out  ALUOP_W  ALU operation code
state  out  4  current state, for debug
illegal_op  out  1  pulses 1 cycle in DECODE for an unsupported opcode

Behaviour:
- Moore FSM. All outputs are decoded from the state register plus OP/Funct latched in the IR (stable from DECODE onward). Outputs not listed for a state are 0.
- ALUOp codes, ALUOP_W bits, zero-extended:
  - R=0, ADDI=1, ORI=2, LUI=3, ANDI=4, BEQ=5, BNE=6, LW=7, SW=8.
  - ADD (used for address/PC arithmetic) = 1.
- Reset (reset==0 at a clk edge):
  - state <- FETCH; illegal_op 0.
  - Reset mid-instruction aborts it; no partial writes occur after the reset edge.
- States, outputs and transitions:
  - FETCH(0): MemRead, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCSource=0.
    - IRWrite and PCWrite are asserted only in the cycle mem_ready==1 (always, if MEM_HANDSHAKE=0).
    - Stay in FETCH until then; next DECODE.
  - DECODE(1): ALUSrcA=0, ALUSrcB=3, ALUOp=ADD (branch target into ALUOut). Next by OP:
    - LW/SW -> MEMADR
    - R-type with JR (EN_JAL_JR) -> JR
    - other R-type -> EXEC_R
    - ADDI/ORI/LUI/ANDI -> EXEC_I
    - BEQ/BNE -> BRANCH
    - J -> JUMP
    - JAL (EN_JAL_JR) -> JAL
    - anything else -> FETCH, with illegal_op=1 for this cycle.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=2, ALUOp=ADD; next LW -> MEMRD, SW -> MEMWR.
  - MEMRD(3): MemRead, IorD=1; holds until mem_ready, then MEMWB.
  - MEMWB(4): RegWrite, RegDst=0, MemtoReg=1; next FETCH.
  - MEMWR(5): MemWrite, IorD=1; holds until mem_ready, then FETCH.
  - EXEC_R(6): ALUSrcA=1, ALUSrcB=0, ALUOp=R; next ALUWB_R.
  - ALUWB_R(7): RegWrite, RegDst=1, MemtoReg=0; next FETCH.
  - EXEC_I(8): ALUSrcA=1, ALUSrcB=2, ALUOp=opcode code; next ALUWB_I.
  - ALUWB_I(9): RegWrite, RegDst=0, MemtoReg=0; next FETCH.
  - BRANCH(10): ALUSrcA=1, ALUSrcB=0, ALUOp=BEQ or BNE code, PCSource=1.
    - PCWriteCondEQ for BEQ, PCWriteCondNE for BNE; next FETCH.
  - JUMP(11): PCWrite, PCSource=2; next FETCH.
  - JAL(12): PCWrite, PCSource=2, RegWrite, RegDst=2, MemtoReg=2.
    - Link value is the PC already incremented in FETCH; next FETCH.
  - JR(13): PCWrite, PCSource=3; next FETCH.
- CPI: branch/jump 3; R/I-type ALU 4; SW 4; LW 5; plus one cycle per mem_ready-low cycle.
- Memory wait: while waiting, strobes stay asserted and stable; IRWrite/PCWrite must not pulse more than once per fetch.
- mem_ready==1 outside FETCH/MEMRD/MEMWR is ignored.
- Unused state encodings (14, 15) -> FETCH on the next edge.

Decomposition:
- Shared package: opcode localparams (R, ADDI 0x08, ORI 0x0d, LUI 0x0f, ANDI 0x0c, BEQ 0x04, BNE 0x05, LW 0x23, SW 0x2b, J 0x02, JAL 0x03), FUNCT_JR 0x08, ALUOp codes, state encodings, and mux-select constants for MemtoReg/RegDst/ALUSrcB/PCSource.
- One natural sub-module: multicycle_next_state (combinational next-state decode from state/OP/Funct/mem_ready).
- Output decode stays in the top.

Test Plan:
- Reset held low 2 cycles mid-MEMRD, then released -> state=0, IRWrite/PCWrite only asserted when mem_ready=1 in FETCH; no RegWrite.
- ADDI (OP=0x08), mem_ready tied 1 -> states 0,1,8,9,0; ALUOp=1 in state 8; RegWrite=1, RegDst=0 only in state 9.
- LW (OP=0x23), mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, MemRead=1 and IorD=1 throughout, MEMWB once, total 8 cycles.
- BNE (OP=0x05) -> states 0,1,10; PCWriteCondNE=1, PCSource=1, ALUOp=6, PCWriteCondEQ=0; back to FETCH after 3 cycles.
- JAL (OP=0x03) with EN_JAL_JR=1 -> state 12 with RegDst=2, MemtoReg=2, PCSource=2; with EN_JAL_JR=0 -> illegal_op pulse in DECODE, next state FETCH, no writes.
- R-type Funct=0x08 (JR) -> state 13, PCSource=3, PCWrite=1, RegWrite=0.
